logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit for the ALU: one block with an opcode select replaces the fixed-width OR/AND/XOR/NOT operators.
- Adds a valid/ready handshake on input and output, a 2-stage pipeline with backpressure, and an accumulator register usable as the Y operand.
- Adds registered zero and parity flags.
- Sits between the ALU operand mux and the result writeback mux.

---
 rtl/logic_unit_pipe.sv | 154 +++++++++++++++
 tb/tb_logic_unit_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module  : logic_unit_pipe
// Brief   : Two-stage valid/ready bitwise logic unit with accumulator Y operand
//           and registered zero/parity flags.
// Revision: 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic             acc_wr,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic [WIDTH-1:0] acc_q
);

    localparam logic [2:0] c_OP_OR   = 3'd0;
    localparam logic [2:0] c_OP_AND  = 3'd1;
    localparam logic [2:0] c_OP_XOR  = 3'd2;
    localparam logic [2:0] c_OP_NOTX = 3'd3;
    localparam logic [2:0] c_OP_NOR  = 3'd4;
    localparam logic [2:0] c_OP_NAND = 3'd5;
    localparam logic [2:0] c_OP_XNOR = 3'd6;

    logic             s1_valid_q,   s1_valid_d;
    logic [WIDTH-1:0] s1_x_q,       s1_x_d;
    logic [WIDTH-1:0] s1_y_q,       s1_y_d;
    logic [2:0]       s1_op_q,      s1_op_d;
    logic             s1_acc_sel_q, s1_acc_sel_d;
    logic             s1_acc_wr_q,  s1_acc_wr_d;
    logic             s2_valid_q,   s2_valid_d;
    logic [WIDTH-1:0] result_q,     result_d;
    logic             zero_q,       zero_d;
    logic             parity_q,     parity_d;
    logic [WIDTH-1:0] acc_d;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [WIDTH-1:0] w_y_op;
    logic [WIDTH-1:0] w_res;

    // in_ready is purely combinational from out_ready: no skid buffer.
    assign w_s2_adv = !s2_valid_q || out_ready;
    assign w_s1_adv = !s1_valid_q || w_s2_adv;
    assign in_ready = w_s1_adv;

    // The accumulator is read at the stage-2 load edge, so a write by the
    // previous beat on the prior edge is already visible here.
    assign w_y_op = s1_acc_sel_q ? acc_q : s1_y_q;

    always_comb begin
        w_res = s1_x_q;
        case (s1_op_q)
            c_OP_OR:   w_res = s1_x_q | w_y_op;
            c_OP_AND:  w_res = s1_x_q & w_y_op;
            c_OP_XOR:  w_res = s1_x_q ^ w_y_op;
            c_OP_NOTX: w_res = ~s1_x_q;
            c_OP_NOR:  w_res = ~(s1_x_q | w_y_op);
            c_OP_NAND: w_res = ~(s1_x_q & w_y_op);
            c_OP_XNOR: w_res = ~(s1_x_q ^ w_y_op);
            default:   w_res = s1_x_q;
        endcase
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_x_d       = s1_x_q;
        s1_y_d       = s1_y_q;
        s1_op_d      = s1_op_q;
        s1_acc_sel_d = s1_acc_sel_q;
        s1_acc_wr_d  = s1_acc_wr_q;
        if (w_s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_x_d       = x;
                s1_y_d       = y;
                s1_op_d      = op;
                s1_acc_sel_d = acc_sel;
                s1_acc_wr_d  = acc_wr;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        zero_d     = zero_q;
        parity_d   = parity_q;
        acc_d      = acc_q;
        if (w_s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = w_res;
                zero_d   = ~|w_res;
                parity_d = ^w_res;
                if (s1_acc_wr_q) begin
                    acc_d = w_res;
                end
            end
        end
        // Clear wins over a coincident accumulate write.
        if (acc_clr) begin
            acc_d = ACC_RST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_op_q      <= 3'd0;
            s1_acc_sel_q <= 1'b0;
            s1_acc_wr_q  <= 1'b0;
            s2_valid_q   <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            parity_q     <= 1'b0;
            acc_q        <= ACC_RST;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_op_q      <= s1_op_d;
            s1_acc_sel_q <= s1_acc_sel_d;
            s1_acc_wr_q  <= s1_acc_wr_d;
            s2_valid_q   <= s2_valid_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            parity_q     <= parity_d;
            acc_q        <= acc_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign parity    = parity_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_logic_unit_pipe
// Brief   : Directed and randomized self-checking bench for logic_unit_pipe
//           against a transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

    localparam int           W        = 8;
    localparam logic [W-1:0] c_ACC_RST = '0;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] x, y;
    logic [2:0]   op;
    logic         acc_sel, acc_wr, acc_clr;
    logic         out_valid, out_ready;
    logic [W-1:0] result;
    logic         zero, parity;
    logic [W-1:0] acc_q;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_acc;

    logic_unit_pipe #(.WIDTH(W), .ACC_RST(c_ACC_RST)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op(op),
        .acc_sel(acc_sel), .acc_wr(acc_wr), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .parity(parity), .acc_q(acc_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Operation table as listed for the ALU opcodes.
    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            3'd0:    return a | b;
            3'd1:    return a & b;
            3'd2:    return a ^ b;
            3'd3:    return ~a;
            3'd4:    return ~(a | b);
            3'd5:    return ~(a & b);
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // One clock: decide transfers at the falling edge, score them, then
    // return 1 time unit after the rising edge.
    task automatic cycle(output bit took);
        bit           t_in, t_out;
        logic [W-1:0] e, yv;
        @(negedge clk);
        t_in  = in_valid && in_ready;
        t_out = out_valid && out_ready;
        if (t_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {63'd0, out_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", {{(64-W){1'b0}}, result}, {{(64-W){1'b0}}, e});
                chk("zero",   {63'd0, zero},   {63'd0, (e == '0)});
                chk("parity", {63'd0, parity}, {63'd0, ^e});
            end
        end
        if (t_in) begin
            yv = acc_sel ? model_acc : y;
            e  = ref_op(op, x, yv);
            if (acc_wr) model_acc = e;
            exp_q.push_back(e);
        end
        took = t_in;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] xi, input logic [W-1:0] yi, input logic [2:0] o,
                        input logic s, input logic wr);
        bit t;
        x = xi; y = yi; op = o; acc_sel = s; acc_wr = wr;
        in_valid = 1'b1;
        t = 1'b0;
        for (int i = 0; i < 20 && !t; i++) cycle(t);
        chk("send_accepted", {63'd0, t}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit t;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(t);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("out_valid_idle", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        bit t;
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; op = 3'd0;
        acc_sel = 1'b0; acc_wr = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        model_acc = c_ACC_RST;

        // Reset state
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {{(64-W){1'b0}}, result}, 64'd0);
        chk("rst_zero",   {63'd0, zero},   64'd0);
        chk("rst_parity", {63'd0, parity}, 64'd0);
        chk("rst_acc", {{(64-W){1'b0}}, acc_q}, {{(64-W){1'b0}}, c_ACC_RST});
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // All opcodes on x=F0, y=3C, back to back, plus two-register latency
        send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
        chk("lat_edge_n", {63'd0, out_valid}, 64'd0);
        send(8'hF0, 8'h3C, 3'd1, 1'b0, 1'b0);
        chk("lat_edge_n1", {63'd0, out_valid}, 64'd1);
        chk("op_or_const", {{(64-W){1'b0}}, result}, 64'hFC);
        for (int k = 2; k < 8; k++) send(8'hF0, 8'h3C, 3'(k), 1'b0, 1'b0);
        drain();

        // Backpressure with a full pipe
        out_ready = 1'b0;
        send(W'($urandom), W'($urandom), 3'd2, 1'b0, 1'b0);
        send(W'($urandom), W'($urandom), 3'd2, 1'b0, 1'b0);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_out_valid", {63'd0, out_valid}, 64'd1);
        x = W'($urandom); y = W'($urandom); op = 3'd2; in_valid = 1'b1;
        repeat (3) begin
            cycle(t);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_hold", {{(64-W){1'b0}}, result}, {{(64-W){1'b0}}, exp_q[0]});
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) send(W'($urandom), W'($urandom), 3'd2, 1'b0, 1'b0);
        drain();

        // Clear then chained accumulate
        acc_clr = 1'b1; cycle(t); acc_clr = 1'b0; model_acc = c_ACC_RST;
        send(8'h01, 8'h00, 3'd0, 1'b1, 1'b1);
        send(8'h02, 8'h00, 3'd0, 1'b1, 1'b1);
        send(8'h80, 8'h00, 3'd0, 1'b1, 1'b1);
        drain();
        chk("acc_chain", {{(64-W){1'b0}}, acc_q}, 64'h83);
        chk("acc_chain_parity", {63'd0, parity}, 64'd1);

        // Clear coincident with the write edge: clear wins, result uses old acc
        send(8'h04, 8'h00, 3'd0, 1'b1, 1'b1);
        acc_clr = 1'b1; cycle(t); acc_clr = 1'b0;
        model_acc = c_ACC_RST;
        chk("clr_wins", {{(64-W){1'b0}}, acc_q}, {{(64-W){1'b0}}, c_ACC_RST});
        chk("clr_preclear_operand", {{(64-W){1'b0}}, result}, 64'h87);
        drain();

        // Zero flag
        send(8'hAA, 8'h55, 3'd1, 1'b0, 1'b0);
        cycle(t);
        chk("zero_flag", {63'd0, zero}, 64'd1);
        chk("zero_parity", {63'd0, parity}, 64'd0);
        drain();

        // Randomized traffic with random stalls and accumulator use
        repeat (400) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            x = W'($urandom); y = W'($urandom); op = 3'($urandom);
            acc_sel = 1'($urandom); acc_wr = 1'($urandom);
            cycle(t);
        end
        drain();
        chk("rand_acc", {{(64-W){1'b0}}, acc_q}, {{(64-W){1'b0}}, model_acc});

        // Reset with two beats in flight
        send(8'h83, 8'h00, 3'd7, 1'b0, 1'b1);
        drain();
        out_ready = 1'b0;
        send(W'($urandom), W'($urandom), 3'd0, 1'b0, 1'b0);
        send(W'($urandom), W'($urandom), 3'd0, 1'b0, 1'b0);
        chk("pre_rst_acc", {{(64-W){1'b0}}, acc_q}, 64'h83);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_acc", {{(64-W){1'b0}}, acc_q}, {{(64-W){1'b0}}, c_ACC_RST});
        exp_q.delete();
        model_acc = c_ACC_RST;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rel_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h5A, 8'h0F, 3'd2, 1'b0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
